// File: rtl/mdu_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit and the hazard unit.
package mdu_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;
  localparam logic [2:0] MD_MADD  = 3'd7;

  localparam int CNT_W = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Multiply/divide unit owning HI/LO; result is computed at start and committed after a fixed latency.
// Optional MADD (md_op 7) accumulate is enabled by defining MDU_MADD_EN.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output mdu_state_e  state_dbg
);

  // Handshake: start is a one-cycle strobe accepted only in IDLE; busy is
  // high exactly for the latency cycles and a start seen while busy is dropped.

  mdu_state_e       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [31:0]      hi_nx, lo_nx, p_hi, p_lo, p_hi_nx, p_lo_nx;
  logic             p_wr, p_wr_nx;

  logic [63:0] prod_s, prod_u;
  logic [31:0] div_b, qu, ru, a_mag, b_mag, q_mag, r_mag, qs, rsgn;

  // Signed divide goes through magnitudes so 0x80000000 / -1 wraps cleanly.
  always_comb begin
    prod_s = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
    prod_u = {32'b0, rs_data} * {32'b0, rt_data};
    div_b  = (rt_data == 32'd0) ? 32'd1 : rt_data;
    qu     = rs_data / div_b;
    ru     = rs_data % div_b;
    a_mag  = rs_data[31] ? -rs_data : rs_data;
    b_mag  = div_b[31] ? -div_b : div_b;
    q_mag  = a_mag / b_mag;
    r_mag  = a_mag % b_mag;
    qs     = (rs_data[31] ^ div_b[31]) ? -q_mag : q_mag;
    rsgn   = rs_data[31] ? -r_mag : r_mag;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    hi_nx    = hi;
    lo_nx    = lo;
    p_hi_nx  = p_hi;
    p_lo_nx  = p_lo;
    p_wr_nx  = p_wr;
    case (state)
      ST_IDLE: begin
        if (start) begin
          case (md_op)
            MD_MULT: begin
              {p_hi_nx, p_lo_nx} = prod_s;
              p_wr_nx  = 1'b1;
              cnt_nx   = CNT_W'(MULT_CYCLES);
              state_nx = ST_BUSY;
            end
            MD_MULTU: begin
              {p_hi_nx, p_lo_nx} = prod_u;
              p_wr_nx  = 1'b1;
              cnt_nx   = CNT_W'(MULT_CYCLES);
              state_nx = ST_BUSY;
            end
            MD_DIV: begin
              p_hi_nx  = rsgn;
              p_lo_nx  = qs;
              p_wr_nx  = (rt_data != 32'd0);
              cnt_nx   = CNT_W'(DIV_CYCLES);
              state_nx = ST_BUSY;
            end
            MD_DIVU: begin
              p_hi_nx  = ru;
              p_lo_nx  = qu;
              p_wr_nx  = (rt_data != 32'd0);
              cnt_nx   = CNT_W'(DIV_CYCLES);
              state_nx = ST_BUSY;
            end
            MD_MTHI: hi_nx = rs_data;
            MD_MTLO: lo_nx = rs_data;
`ifdef MDU_MADD_EN
            MD_MADD: begin
              {p_hi_nx, p_lo_nx} = {hi, lo} + prod_s;
              p_wr_nx  = 1'b1;
              cnt_nx   = CNT_W'(MULT_CYCLES);
              state_nx = ST_BUSY;
            end
`endif
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        if (cnt <= CNT_W'(1)) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
          if (p_wr) begin
            hi_nx = p_hi;
            lo_nx = p_lo;
          end
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      p_wr  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      hi    <= hi_nx;
      lo    <= lo_nx;
      p_hi  <= p_hi_nx;
      p_lo  <= p_lo_nx;
      p_wr  <= p_wr_nx;
    end
  end

  assign busy      = (state == ST_BUSY);
  assign state_dbg = state;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset && start && state == ST_BUSY && md_op != MD_NONE)
      $warning("mul_div_unit: start while busy dropped (md_op=%0d)", md_op);
  end
`endif

endmodule
